// File: rtl/func_unit_mc.sv
// func_unit_mc: multi-cycle function unit sitting behind the register file.
// Single-cycle ALU/logic/shift operations return a result on the cycle after
// START. Unsigned multiply runs as a WIDTH-step shift-add sequence under a
// START/BUSY/DONE handshake, so write-back control can stall on it.

module func_unit_mc #(
   parameter int WIDTH = 16
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       FS,
   input  logic             START,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] F,
   output logic             V,
   output logic             C,
   output logic             N,
   output logic             Z
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   typedef enum logic {
      S_IDLE,
      S_MUL
   } state_t;

   state_t             r_state;
   logic [2*WIDTH-1:0] r_prod;
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [CW-1:0]      r_cnt;

   logic [WIDTH-1:0]   w_bOp;
   logic               w_cin;
   logic [WIDTH:0]     w_sum;
   logic [WIDTH-1:0]   w_res;
   logic               w_c;
   logic               w_v;
   logic [2*WIDTH-1:0] w_prodNext;
   logic [WIDTH-1:0]   w_mulLow;
   logic               w_mulHigh;

   // Pick the second adder operand and carry-in so every arithmetic op shares one adder
   always_comb begin
      w_bOp = '0;
      w_cin = 1'b0;
      case (FS)
         4'b0001: begin w_bOp = '0;  w_cin = 1'b1; end
         4'b0010: begin w_bOp = B;   w_cin = 1'b0; end
         4'b0011: begin w_bOp = B;   w_cin = 1'b1; end
         4'b0100: begin w_bOp = ~B;  w_cin = 1'b0; end
         4'b0101: begin w_bOp = ~B;  w_cin = 1'b1; end
         4'b0110: begin w_bOp = '1;  w_cin = 1'b0; end
         default: begin w_bOp = '0;  w_cin = 1'b0; end
      endcase
   end

   assign w_sum = {1'b0, A} + {1'b0, w_bOp} + {{WIDTH{1'b0}}, w_cin};

   // Single-cycle result and C/V flags for the selected function
   always_comb begin
      w_res = '0;
      w_c   = 1'b0;
      w_v   = 1'b0;
      if (!FS[3]) begin
         w_res = w_sum[WIDTH-1:0];
         w_c   = w_sum[WIDTH];
         w_v   = (A[WIDTH-1] == w_bOp[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
      end else begin
         case (FS[2:0])
            3'b000: w_res = A & B;
            3'b001: w_res = A | B;
            3'b010: w_res = A ^ B;
            3'b011: w_res = ~A;
            3'b100: w_res = B;
            3'b101: begin
               w_res = B >> 1;
               w_c   = B[0];
            end
            3'b110: begin
               w_res = B << 1;
               w_c   = B[WIDTH-1];
            end
            default: w_res = '0;
         endcase
      end
   end

   // One shift-add step: accumulate the shifted multiplicand when the current multiplier bit is set
   always_comb begin
      w_prodNext = r_prod + (r_mplier[0] ? r_mcand : '0);
      w_mulLow   = w_prodNext[WIDTH-1:0];
      w_mulHigh  = |w_prodNext[2*WIDTH-1:WIDTH];
   end

   // Control FSM plus all registered outputs; DONE defaults low and pulses on completion edges
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state  <= S_IDLE;
         r_prod   <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
         F        <= '0;
         V        <= 1'b0;
         C        <= 1'b0;
         N        <= 1'b0;
         Z        <= 1'b0;
      end else begin
         DONE <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (START) begin
                  if (FS == 4'b1111) begin
                     r_prod   <= '0;
                     r_mcand  <= {{WIDTH{1'b0}}, A};
                     r_mplier <= B;
                     r_cnt    <= '0;
                     BUSY     <= 1'b1;
                     r_state  <= S_MUL;
                  end else begin
                     F    <= w_res;
                     C    <= w_c;
                     V    <= w_v;
                     N    <= w_res[WIDTH-1];
                     Z    <= (w_res == '0);
                     DONE <= 1'b1;
                  end
               end
            end
            S_MUL: begin
               r_prod   <= w_prodNext;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + 1'b1;
               if (r_cnt == LAST_STEP) begin
                  F       <= w_mulLow;
                  C       <= w_mulHigh;
                  V       <= 1'b0;
                  N       <= w_mulLow[WIDTH-1];
                  Z       <= (w_mulLow == '0);
                  BUSY    <= 1'b0;
                  DONE    <= 1'b1;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
               BUSY    <= 1'b0;
            end
         endcase
      end
   end

endmodule
